// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exponent-compare codes and default field widths.
package fpu_pkg;

    localparam int unsigned EXP_WIDTH_DEF = 8;
    localparam int unsigned MAN_WIDTH_DEF = 23;

    // Exponent comparator result; 2'b01 is unused and handled like A_LESS.
    typedef enum logic [1:0] {
        A_LESS    = 2'b00,
        A_RSVD    = 2'b01,
        A_GREATER = 2'b10,
        A_EQUAL   = 2'b11
    } exp_disc_e;

endpackage

// File: rtl/grs_shifter.sv
// Right shift of an extended significand with sticky collection into bit 0.
module grs_shifter #(
    parameter int unsigned AW = 27
) (
    input  logic [AW-1:0] i_din,
    input  logic [4:0]    i_shift,
    output logic [AW-1:0] o_dout
);

    logic [AW-1:0] w_one;
    logic [AW-1:0] w_shifted;
    logic [AW-1:0] w_lost_mask;
    logic          w_sticky;

    assign w_one = {{(AW-1){1'b0}}, 1'b1};

    // Shift, then OR every bit that fell off the bottom into the LSB.
    always_comb begin
        w_shifted   = '0;
        w_lost_mask = '0;
        if (32'(i_shift) >= AW) begin
            w_shifted   = '0;
            w_lost_mask = '1;
        end else begin
            w_shifted   = i_din >> i_shift;
            w_lost_mask = (w_one << i_shift) - w_one;
        end
        w_sticky = |(i_din & w_lost_mask);
        o_dout   = {w_shifted[AW-1:1], w_shifted[0] | w_sticky};
    end

endmodule

// File: rtl/mantissa_align.sv
// Two-stage valid/ready pipeline: S1 picks the larger operand, S2 aligns the
// smaller significand with guard/round/sticky bits.
module mantissa_align
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int unsigned MAN_WIDTH = MAN_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           exp_disc,
    input  logic [4:0]           shift_spaces,
    input  logic [EXP_WIDTH-1:0] exp_value,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [MAN_WIDTH:0]   man_a,
    input  logic [MAN_WIDTH:0]   man_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_WIDTH+3:0] man_big,
    output logic [MAN_WIDTH+3:0] man_small,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic                 sign_big,
    output logic                 sign_small,
    output logic                 swapped
);

    localparam int unsigned SW = MAN_WIDTH + 1;
    localparam int unsigned AW = SW + 3;

    // Stage 1 registers
    logic                 r_s1_valid;
    logic [SW-1:0]        r_s1_big;
    logic [SW-1:0]        r_s1_small;
    logic                 r_s1_sign_big;
    logic                 r_s1_sign_small;
    logic                 r_s1_swapped;
    logic [EXP_WIDTH-1:0] r_s1_exp;
    logic [4:0]           r_s1_shift;

    // Stage 2 (output) registers
    logic                 r_s2_valid;
    logic [AW-1:0]        r_man_big;
    logic [AW-1:0]        r_man_small;
    logic [EXP_WIDTH-1:0] r_exp_out;
    logic                 r_sign_big;
    logic                 r_sign_small;
    logic                 r_swapped;

    logic                 w_s2_ready;
    logic                 w_pick_b;
    logic [AW-1:0]        w_small_ext;
    logic [AW-1:0]        w_small_aligned;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;

    // Operand select: B becomes the big operand on A_LESS (and the unused
    // code), or on A_EQUAL when B's significand is strictly larger.
    always_comb begin
        w_pick_b = 1'b0;
        case (exp_disc_e'(exp_disc))
            A_GREATER: w_pick_b = 1'b0;
            A_EQUAL:   w_pick_b = (man_b > man_a);
            default:   w_pick_b = 1'b1;
        endcase
    end

    // Stage 1: capture ordered operands when the upstream transfer happens.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_s1_valid      <= 1'b0;
            r_s1_big        <= '0;
            r_s1_small      <= '0;
            r_s1_sign_big   <= 1'b0;
            r_s1_sign_small <= 1'b0;
            r_s1_swapped    <= 1'b0;
            r_s1_exp        <= '0;
            r_s1_shift      <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_big        <= w_pick_b ? man_b : man_a;
                r_s1_small      <= w_pick_b ? man_a : man_b;
                r_s1_sign_big   <= w_pick_b ? sign_b : sign_a;
                r_s1_sign_small <= w_pick_b ? sign_a : sign_b;
                r_s1_swapped    <= w_pick_b;
                r_s1_exp        <= exp_value;
                r_s1_shift      <= shift_spaces;
            end
        end
    end

    assign w_small_ext = {r_s1_small, 3'b000};

    grs_shifter #(
        .AW (AW)
    ) u_grs_shifter (
        .i_din   (w_small_ext),
        .i_shift (r_s1_shift),
        .o_dout  (w_small_aligned)
    );

    // Stage 2: register the aligned pair; holds while downstream stalls.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_s2_valid   <= 1'b0;
            r_man_big    <= '0;
            r_man_small  <= '0;
            r_exp_out    <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_swapped    <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_man_big    <= {r_s1_big, 3'b000};
                r_man_small  <= w_small_aligned;
                r_exp_out    <= r_s1_exp;
                r_sign_big   <= r_s1_sign_big;
                r_sign_small <= r_s1_sign_small;
                r_swapped    <= r_s1_swapped;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign man_big    = r_man_big;
    assign man_small  = r_man_small;
    assign exp_out    = r_exp_out;
    assign sign_big   = r_sign_big;
    assign sign_small = r_sign_small;
    assign swapped    = r_swapped;

endmodule

// File: tb/tb_mantissa_align.sv
// Directed-vector bench for mantissa_align with hand-computed expectations.
module tb_mantissa_align;

    localparam int unsigned EW = 8;
    localparam int unsigned MW = 23;
    localparam int unsigned SW = MW + 1;
    localparam int unsigned AW = SW + 3;

    logic          clk;
    logic          arst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    exp_disc;
    logic [4:0]    shift_spaces;
    logic [EW-1:0] exp_value;
    logic          sign_a;
    logic          sign_b;
    logic [SW-1:0] man_a;
    logic [SW-1:0] man_b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] man_big;
    logic [AW-1:0] man_small;
    logic [EW-1:0] exp_out;
    logic          sign_big;
    logic          sign_small;
    logic          swapped;

    typedef struct {
        logic [1:0]    disc;
        logic [4:0]    shift;
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic          sa;
        logic          sb;
        logic [EW-1:0] expv;
        logic [AW-1:0] e_big;
        logic [AW-1:0] e_small;
        logic          e_swap;
        logic          e_sbig;
        logic          e_ssmall;
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    mantissa_align #(
        .EXP_WIDTH (EW),
        .MAN_WIDTH (MW)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .exp_disc     (exp_disc),
        .shift_spaces (shift_spaces),
        .exp_value    (exp_value),
        .sign_a       (sign_a),
        .sign_b       (sign_b),
        .man_a        (man_a),
        .man_b        (man_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .man_big      (man_big),
        .man_small    (man_small),
        .exp_out      (exp_out),
        .sign_big     (sign_big),
        .sign_small   (sign_small),
        .swapped      (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_vec(input int i);
        exp_disc     = vecs[i].disc;
        shift_spaces = vecs[i].shift;
        man_a        = vecs[i].a;
        man_b        = vecs[i].b;
        sign_a       = vecs[i].sa;
        sign_b       = vecs[i].sb;
        exp_value    = vecs[i].expv;
    endtask

    task automatic check_out(input int i);
        check_val($sformatf("v%0d.big", i),    64'(man_big),    64'(vecs[i].e_big));
        check_val($sformatf("v%0d.small", i),  64'(man_small),  64'(vecs[i].e_small));
        check_val($sformatf("v%0d.swap", i),   64'(swapped),    64'(vecs[i].e_swap));
        check_val($sformatf("v%0d.sbig", i),   64'(sign_big),   64'(vecs[i].e_sbig));
        check_val($sformatf("v%0d.ssmall", i), 64'(sign_small), 64'(vecs[i].e_ssmall));
        check_val($sformatf("v%0d.exp", i),    64'(exp_out),    64'(vecs[i].expv));
    endtask

    // Single item through an otherwise empty pipe, out_ready held high.
    task automatic run_vec(input int i);
        drive_vec(i);
        in_valid = 1'b1;
        #1;
        check_val($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_val($sformatf("v%0d.lat1", i), 64'(out_valid), 64'd0);
        @(negedge clk);
        check_val($sformatf("v%0d.lat2", i), 64'(out_valid), 64'd1);
        check_out(i);
        @(negedge clk);
    endtask

    initial begin
        //              disc   sh  a           b           sa    sb    exp    big           small         sw    sbig  ssml
        vecs[0] = '{2'b10,  3, 24'h800000, 24'hC00000, 1'b0, 1'b1, 8'h85, 27'h4000000, 27'h0C00000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{2'b00,  1, 24'h800001, 24'h800000, 1'b1, 1'b0, 8'h7F, 27'h4000000, 27'h2000004, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 30, 24'h800000, 24'h000001, 1'b0, 1'b0, 8'h90, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11,  0, 24'h900000, 24'hA00000, 1'b1, 1'b1, 8'h01, 27'h5000000, 27'h4800000, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{2'b01,  2, 24'hFFFFFF, 24'h800000, 1'b0, 1'b1, 8'hFE, 27'h4000000, 27'h1FFFFFE, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{2'b10,  5, 24'hC00000, 24'h800001, 1'b1, 1'b0, 8'h40, 27'h6000000, 27'h0200001, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2'b11,  0, 24'h800000, 24'h800000, 1'b0, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 27, 24'h800000, 24'h000000, 1'b0, 1'b0, 8'h00, 27'h4000000, 27'h0000000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{2'b10, 26, 24'h800000, 24'h800000, 1'b0, 1'b0, 8'hFF, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{2'b11,  4, 24'hA00000, 24'h900000, 1'b1, 1'b1, 8'h33, 27'h5000000, 27'h0480000, 1'b0, 1'b1, 1'b1};

        arst_n    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_vec(0);

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst.out_valid", 64'(out_valid), 64'd0);
        check_val("rst.in_ready",  64'(in_ready),  64'd1);
        check_val("rst.man_big",   64'(man_big),   64'd0);
        check_val("rst.man_small", 64'(man_small), 64'd0);
        check_val("rst.swapped",   64'(swapped),   64'd0);
        check_val("rst.exp_out",   64'(exp_out),   64'd0);
        arst_n = 1'b1;
        #1;
        check_val("rel.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed vectors one at a time
        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-to-back with downstream stalled for four cycles
        out_ready = 1'b0;
        drive_vec(3);
        in_valid = 1'b1;
        #1;
        check_val("b2b.rdy0", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive_vec(4);
        check_val("b2b.rdy1", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive_vec(5);
        check_val("b2b.full",  64'(in_ready),  64'd0);
        check_val("b2b.ovld",  64'(out_valid), 64'd1);
        @(negedge clk);
        check_val("b2b.full2", 64'(in_ready),  64'd0);
        check_val("b2b.hold1", 64'(man_small), 64'(vecs[3].e_small));
        @(negedge clk);
        check_val("b2b.full3", 64'(in_ready),  64'd0);
        check_val("b2b.hold2", 64'(man_small), 64'(vecs[3].e_small));
        check_val("b2b.hold3", 64'(man_big),   64'(vecs[3].e_big));
        out_ready = 1'b1;
        begin
            int got;
            got = 0;
            for (int k = 0; k < 10; k++) begin
                if (out_valid) begin
                    check_out(3 + got);
                    got++;
                end
                if (got == 3) break;
                @(negedge clk);
                in_valid = 1'b0;
            end
            check_val("b2b.count", 64'(got), 64'd3);
        end
        @(negedge clk);
        check_val("b2b.empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with items in both stages
        out_ready = 1'b0;
        drive_vec(0);
        in_valid = 1'b1;
        @(negedge clk);
        drive_vec(1);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("arst.pre", 64'(out_valid), 64'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check_val("arst.out_valid", 64'(out_valid), 64'd0);
        check_val("arst.in_ready",  64'(in_ready),  64'd1);
        check_val("arst.man_big",   64'(man_big),   64'd0);
        check_val("arst.man_small", 64'(man_small), 64'd0);
        check_val("arst.swapped",   64'(swapped),   64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check_val("arst.rel_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val($sformatf("arst.stale%0d", k), 64'(out_valid), 64'd0);
        end
        run_vec(9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
